// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline control unit
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_PEND  = 2'd2,
    ST_HOLD  = 2'd3
  } ctrl_state_e;

  localparam int          CTRL_FLUSH_W         = 4;
  localparam int          CTRL_HOLD_W          = 8;
  localparam logic [31:0] CTRL_ADDR_ALIGN_MASK = 32'hFFFF_FFFC;

  function automatic logic [31:0] align_addr(input logic [31:0] addr);
    return addr & CTRL_ADDR_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/ctrl_sat_cnt.sv
// rtl/ctrl_sat_cnt.sv - saturating up-counter with clear
// A clear that coincides with an increment restarts the count at 1.
module ctrl_sat_cnt #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] MAX   = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr_i) begin
      r_cnt <= inc_i ? WIDTH'(1) : '0;
    end else if (inc_i && (r_cnt != MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt_o = r_cnt;

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - PC redirect, flush sequencing and hold control for fetch/decode
// Redirect and hold decisions are combinational; flags and counters are registered.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int HOLD_MAX     = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_flag_i,
  input  logic        ext_hold_i,
  output logic        pc_jump_en_o,
  output logic [31:0] pc_jump_addr_o,
  output logic        flush_o,
  output logic        hold_o,
  output logic        misalign_err_o,
  output logic        hold_timeout_o,
  output logic [15:0] redirect_cnt_o
);

  localparam logic [CTRL_FLUSH_W-1:0] FLUSH_INIT = CTRL_FLUSH_W'(FLUSH_CYCLES - 1);
  localparam logic [CTRL_HOLD_W-1:0]  HOLD_LIMIT = CTRL_HOLD_W'(HOLD_MAX);
  localparam logic [CTRL_HOLD_W-1:0]  HOLD_LAST  = CTRL_HOLD_W'(HOLD_MAX - 1);

  ctrl_state_e             r_state;
  logic [CTRL_FLUSH_W-1:0] r_flush_cnt;
  logic [31:0]             r_pend_addr;
  logic                    r_misalign;
  logic                    r_hold_timeout;

  logic                    w_hold_req;
  logic                    w_accept;
  logic [31:0]             w_target;
  logic                    w_hold;
  logic                    w_flush;
  logic                    w_hold_inc;
  logic                    w_hold_clr;
  logic                    w_hold_hit;
  logic [CTRL_HOLD_W-1:0]  w_hold_cnt;
  logic [15:0]             w_redirect_cnt;

  always_comb begin
    w_hold_req = hold_flag_i | ext_hold_i;
    w_accept   = 1'b0;
    w_target   = jump_addr_i;
    w_hold     = 1'b0;
    w_flush    = 1'b0;
    w_hold_inc = 1'b0;
    w_hold_clr = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (jump_en_i) begin
          if (ext_hold_i) w_hold = 1'b1;
          else            w_accept = 1'b1;
        end else if (w_hold_req) begin
          w_hold     = 1'b1;
          w_hold_inc = 1'b1;
        end
      end
      ST_PEND: begin
        w_target = r_pend_addr;
        if (ext_hold_i) w_hold = 1'b1;
        else            w_accept = 1'b1;
      end
      ST_HOLD: begin
        if (w_hold_req) begin
          w_hold     = 1'b1;
          w_hold_inc = 1'b1;
        end else begin
          // Release cycle behaves as IDLE; ext_hold_i is known low here.
          w_hold_clr = 1'b1;
          w_accept   = jump_en_i;
        end
      end
      ST_FLUSH: begin
        w_flush = 1'b1;
        w_hold  = ext_hold_i;
      end
      default: ;
    endcase
    if (w_accept) w_flush = 1'b1;
  end

  assign w_hold_hit = w_hold_inc && (w_hold_cnt == HOLD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_flush_cnt    <= '0;
      r_pend_addr    <= '0;
      r_misalign     <= 1'b0;
      r_hold_timeout <= 1'b0;
    end else begin
      if (w_accept && (w_target[1:0] != 2'b00)) r_misalign <= 1'b1;
      if (w_hold_hit) r_hold_timeout <= 1'b1;
      if (w_accept) begin
        r_flush_cnt <= FLUSH_INIT;
        r_state     <= (FLUSH_CYCLES == 1) ? ST_IDLE : ST_FLUSH;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (jump_en_i) begin
              r_pend_addr <= jump_addr_i;
              r_state     <= ST_PEND;
            end else if (w_hold_req) begin
              r_state <= ST_HOLD;
            end
          end
          ST_PEND: ;
          ST_HOLD: begin
            if (!w_hold_req) r_state <= ST_IDLE;
          end
          ST_FLUSH: begin
            if (!ext_hold_i) begin
              if (r_flush_cnt <= CTRL_FLUSH_W'(1)) begin
                r_flush_cnt <= '0;
                r_state     <= ST_IDLE;
              end else begin
                r_flush_cnt <= r_flush_cnt - 1'b1;
              end
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  ctrl_sat_cnt #(
    .WIDTH (CTRL_HOLD_W),
    .MAX   (HOLD_LIMIT)
  ) u_hold_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (w_hold_clr),
    .inc_i (w_hold_inc),
    .cnt_o (w_hold_cnt)
  );

  ctrl_sat_cnt #(
    .WIDTH (16),
    .MAX   (16'hFFFF)
  ) u_redirect_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (1'b0),
    .inc_i (w_accept),
    .cnt_o (w_redirect_cnt)
  );

  assign pc_jump_en_o   = rst_n & w_accept;
  assign pc_jump_addr_o = (rst_n && w_accept) ? align_addr(w_target) : 32'h0;
  assign flush_o        = rst_n & w_flush;
  assign hold_o         = rst_n & w_hold;
  assign misalign_err_o = rst_n & r_misalign;
  assign hold_timeout_o = rst_n & r_hold_timeout;
  assign redirect_cnt_o = rst_n ? w_redirect_cnt : 16'h0;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - scoreboard bench for pipe_ctrl
module tb_pipe_ctrl;

  logic        clk;
  logic        rst_n;
  logic        jump_en_i;
  logic [31:0] jump_addr_i;
  logic        hold_flag_i;
  logic        ext_hold_i;
  logic        pc_jump_en_o;
  logic [31:0] pc_jump_addr_o;
  logic        flush_o;
  logic        hold_o;
  logic        misalign_err_o;
  logic        hold_timeout_o;
  logic [15:0] redirect_cnt_o;

  typedef struct {
    string       name;
    logic        je;
    logic [31:0] addr;
    logic        fl;
    logic        ho;
    logic        mis;
    logic        to;
    logic [15:0] cnt;
  } exp_t;

  exp_t        cyc_q[$];
  logic [31:0] redir_q[$];
  exp_t        m_e;
  logic [31:0] m_a;
  int          errors = 0;
  int          checks = 0;

  pipe_ctrl #(.FLUSH_CYCLES(2), .HOLD_MAX(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .jump_en_i      (jump_en_i),
    .jump_addr_i    (jump_addr_i),
    .hold_flag_i    (hold_flag_i),
    .ext_hold_i     (ext_hold_i),
    .pc_jump_en_o   (pc_jump_en_o),
    .pc_jump_addr_o (pc_jump_addr_o),
    .flush_o        (flush_o),
    .hold_o         (hold_o),
    .misalign_err_o (misalign_err_o),
    .hold_timeout_o (hold_timeout_o),
    .redirect_cnt_o (redirect_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input string nm, input logic je, input logic [31:0] ja, input logic hf,
                      input logic eh, input logic rn, input logic e_je, input logic [31:0] e_addr,
                      input logic e_fl, input logic e_ho, input logic e_mis, input logic e_to,
                      input logic [15:0] e_cnt);
    exp_t e;
    jump_en_i   = je;
    jump_addr_i = ja;
    hold_flag_i = hf;
    ext_hold_i  = eh;
    rst_n       = rn;
    e.name = nm; e.je = e_je; e.addr = e_addr; e.fl = e_fl;
    e.ho = e_ho; e.mis = e_mis; e.to = e_to; e.cnt = e_cnt;
    cyc_q.push_back(e);
    if (e_je) redir_q.push_back(e_addr);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (cyc_q.size() > 0) begin
      m_e = cyc_q.pop_front();
      checks++;
      if ({pc_jump_en_o, pc_jump_addr_o, flush_o, hold_o, misalign_err_o, hold_timeout_o, redirect_cnt_o}
          !== {m_e.je, m_e.addr, m_e.fl, m_e.ho, m_e.mis, m_e.to, m_e.cnt}) begin
        errors++;
        $display("FAIL %s: got je=%0b addr=%h fl=%0b ho=%0b mis=%0b to=%0b cnt=%0d, expected je=%0b addr=%h fl=%0b ho=%0b mis=%0b to=%0b cnt=%0d",
                 m_e.name, pc_jump_en_o, pc_jump_addr_o, flush_o, hold_o, misalign_err_o,
                 hold_timeout_o, redirect_cnt_o, m_e.je, m_e.addr, m_e.fl, m_e.ho, m_e.mis,
                 m_e.to, m_e.cnt);
      end
    end
    if (pc_jump_en_o === 1'b1) begin
      checks++;
      if (redir_q.size() == 0) begin
        errors++;
        $display("FAIL redirect_unexpected: got addr=%h, expected no redirect", pc_jump_addr_o);
      end else begin
        m_a = redir_q.pop_front();
        if (pc_jump_addr_o !== m_a) begin
          errors++;
          $display("FAIL redirect_addr: got %h, expected %h", pc_jump_addr_o, m_a);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL sim_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; jump_en_i = 1'b0; jump_addr_i = 32'h0; hold_flag_i = 1'b0; ext_hold_i = 1'b0;
    @(posedge clk);
    #1;
    //    name              je ja            hf eh rn   je addr          fl ho mis to cnt
    step("rst_a",           1, 32'h100,      0, 0, 0,   0, 32'h0,        0, 0, 0, 0, 16'd0);
    step("rst_b",           1, 32'h100,      0, 0, 0,   0, 32'h0,        0, 0, 0, 0, 16'd0);
    step("idle",            0, 32'h0,        0, 0, 1,   0, 32'h0,        0, 0, 0, 0, 16'd0);
    step("jmp0",            1, 32'h100,      0, 0, 1,   1, 32'h100,      1, 0, 0, 0, 16'd0);
    step("jmp1_wrongpath",  1, 32'h200,      0, 0, 1,   0, 32'h0,        1, 0, 0, 0, 16'd1);
    step("jmp2",            0, 32'h0,        0, 0, 1,   0, 32'h0,        0, 0, 0, 0, 16'd1);
    step("def0",            1, 32'h40,       0, 1, 1,   0, 32'h0,        0, 1, 0, 0, 16'd1);
    step("def1",            1, 32'h80,       0, 1, 1,   0, 32'h0,        0, 1, 0, 0, 16'd1);
    step("def2",            0, 32'h80,       0, 1, 1,   0, 32'h0,        0, 1, 0, 0, 16'd1);
    step("def3_issue",      0, 32'h80,       0, 0, 1,   1, 32'h40,       1, 0, 0, 0, 16'd1);
    step("def4",            0, 32'h0,        0, 0, 1,   0, 32'h0,        1, 0, 0, 0, 16'd2);
    step("def5",            0, 32'h0,        0, 0, 1,   0, 32'h0,        0, 0, 0, 0, 16'd2);
    step("fx0",             1, 32'h300,      0, 0, 1,   1, 32'h300,      1, 0, 0, 0, 16'd2);
    step("fx1_frozen",      0, 32'h0,        0, 1, 1,   0, 32'h0,        1, 1, 0, 0, 16'd3);
    step("fx2_frozen",      1, 32'h340,      1, 1, 1,   0, 32'h0,        1, 1, 0, 0, 16'd3);
    step("fx3_last",        0, 32'h0,        0, 0, 1,   0, 32'h0,        1, 0, 0, 0, 16'd3);
    step("fx4_done",        0, 32'h0,        0, 0, 1,   0, 32'h0,        0, 0, 0, 0, 16'd3);
    step("mis0",            1, 32'h102,      0, 0, 1,   1, 32'h100,      1, 0, 0, 0, 16'd3);
    step("mis1",            0, 32'h0,        0, 0, 1,   0, 32'h0,        1, 0, 1, 0, 16'd4);
    step("mis2",            0, 32'h0,        0, 0, 1,   0, 32'h0,        0, 0, 1, 0, 16'd4);
    for (int i = 0; i < 16; i++)
      step("wdog_hold",     0, 32'h0,        1, 0, 1,   0, 32'h0,        0, 1, 1, 0, 16'd4);
    step("wdog_release",    0, 32'h0,        0, 0, 1,   0, 32'h0,        0, 0, 1, 1, 16'd4);
    step("h0",              0, 32'h0,        1, 0, 1,   0, 32'h0,        0, 1, 1, 1, 16'd4);
    step("h1",              0, 32'h0,        1, 0, 1,   0, 32'h0,        0, 1, 1, 1, 16'd4);
    step("hold_rel_jump",   1, 32'h500,      0, 0, 1,   1, 32'h500,      1, 0, 1, 1, 16'd4);
    step("hj1",             0, 32'h0,        0, 0, 1,   0, 32'h0,        1, 0, 1, 1, 16'd5);
    step("hj2",             0, 32'h0,        0, 0, 1,   0, 32'h0,        0, 0, 1, 1, 16'd5);
    step("jump_beats_hold", 1, 32'h700,      1, 0, 1,   1, 32'h700,      1, 0, 1, 1, 16'd5);
    step("win1",            0, 32'h0,        1, 0, 1,   0, 32'h0,        1, 0, 1, 1, 16'd6);
    step("win2",            0, 32'h0,        0, 0, 1,   0, 32'h0,        0, 0, 1, 1, 16'd6);
    step("rp0_pend",        1, 32'h600,      0, 1, 1,   0, 32'h0,        0, 1, 1, 1, 16'd6);
    step("rp1_reset",       1, 32'h600,      0, 1, 0,   0, 32'h0,        0, 0, 0, 0, 16'd0);
    step("rp2_no_redirect", 0, 32'h0,        0, 0, 1,   0, 32'h0,        0, 0, 0, 0, 16'd0);
    step("rp3_idle",        0, 32'h0,        0, 0, 1,   0, 32'h0,        0, 0, 0, 0, 16'd0);
    @(negedge clk);
    #1;
    checks++;
    if (cyc_q.size() != 0) begin
      errors++;
      $display("FAIL cycle_queue_drain: got %0d left, expected 0", cyc_q.size());
    end
    checks++;
    if (redir_q.size() != 0) begin
      errors++;
      $display("FAIL redirect_queue_drain: got %0d left, expected 0", redir_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control unit that consumes the branch/jump and hold requests produced by the execute stage. It drives the PC redirect and the flush/hold controls for the fetch and decode pipeline registers. It sequences multi-cycle flushes after a taken redirect, defers a redirect that arrives during an external bus stall, and keeps sticky error flags and a redirect count for debug.

## Interface
- FLUSH_CYCLES, 2, cycles `flush_o` stays high per accepted redirect, including the redirect cycle; legal range 1..15
- HOLD_MAX, 16, consecutive hold cycles that set the hold watchdog; legal range 2..255
- clk  input  1  system clock; the only clock
- rst_n  input  1  reset; asynchronous, active-low
- jump_en_i  input  1  taken branch/jump from execute stage
- jump_addr_i  input  32  redirect target from execute stage
- hold_flag_i  input  1  execute-stage stall request
- ext_hold_i  input  1  bus/memory stall request
- pc_jump_en_o  output  1  load PC with `pc_jump_addr_o` at next edge
- pc_jump_addr_o  output  32  redirect target, bits [1:0] forced 0
- flush_o  output  1  replace if_id/id_ex contents with NOP at next edge
- hold_o  output  1  freeze PC and pipeline registers
- misalign_err_o  output  1  sticky; an accepted target had bits [1:0] != 0
- hold_timeout_o  output  1  sticky; hold lasted HOLD_MAX consecutive cycles
- redirect_cnt_o  output  16  accepted redirects, saturates at 16'hFFFF

## Operation
- States: IDLE, FLUSH, PEND, HOLD.
- Reset values: state IDLE, all counters 0, pending address 0, sticky flags 0. While `rst_n` is low, every output is 0, including the combinational outputs, which are gated by `rst_n`.
- **IDLE, `jump_en_i` = 1, `ext_hold_i` = 0 (accept):**
  - `pc_jump_en_o` = 1, `pc_jump_addr_o` = {`jump_addr_i`[31:2], 2'b00}, `flush_o` = 1.
  - `redirect_cnt_o` increments; `misalign_err_o` sets if `jump_addr_i`[1:0] != 0.
  - Next state: FLUSH with the flush counter = FLUSH_CYCLES-1, or IDLE if FLUSH_CYCLES = 1.
- **IDLE, `jump_en_i` = 1, `ext_hold_i` = 1:** `hold_o` = 1, no redirect. Latch `jump_addr_i` into the pending register; next state PEND.
- **IDLE, no jump, `hold_flag_i` or `ext_hold_i` = 1:** `hold_o` = 1; the hold counter loads 1; next state HOLD.
- **PEND:**
  - `hold_o` = 1 while `ext_hold_i` = 1; `jump_en_i` and `jump_addr_i` are ignored.
  - On the first cycle with `ext_hold_i` = 0, perform an accept using the pending address, with the same outputs, counters and next-state rules as IDLE.
- **HOLD:**
  - `hold_o` = 1 while `hold_flag_i` or `ext_hold_i` is high; the counter increments and saturates at HOLD_MAX.
  - `hold_timeout_o` sets on the edge where the counter reaches HOLD_MAX; the hold is still honoured.
  - When both requests are low: `hold_o` = 0, the counter clears, and IDLE rules apply that same cycle, so a jump in that cycle is accepted.
- **FLUSH:**
  - `flush_o` = 1; `jump_en_i` and `hold_flag_i` are ignored, because they come from a wrong-path instruction.
  - `ext_hold_i` = 1 sets `hold_o` = 1 (`flush_o` stays 1) and freezes the counter.
  - Otherwise the counter decrements; return to IDLE when it reaches 0.
- Simultaneous `jump_en_i` and `hold_flag_i` in IDLE: the jump wins.
- Reset asserted in any state: immediate return to reset values; a pending redirect is discarded.

## Timing
- Accepting a redirect has zero latency: outputs are combinational in the accept cycle, and the PC and pipeline registers update at the next edge.
- Flush occupies exactly FLUSH_CYCLES unstalled cycles, counted from the accept cycle.
- A deferred redirect issues in the first cycle `ext_hold_i` is low.
- `hold_o` follows the hold requests combinationally; its deassertion has zero latency.
- Sticky flags and `redirect_cnt_o` are registered and visible one cycle after the triggering cycle.

## Structure
- `defines.v` gains:
  - state encodings (2-bit)
  - `CTRL_FLUSH_W` (4) and `CTRL_HOLD_W` (8) widths
  - `CTRL_ADDR_ALIGN_MASK` (32'hFFFF_FFFC)
- One sub-module, `ctrl_sat_cnt`: a parameterised-width saturating up-counter with clear. It is instantiated for the hold watchdog and for `redirect_cnt_o`.

## Test plan
- Reset: `rst_n` = 0 with `jump_en_i` = 1 → all outputs 0; after release, `redirect_cnt_o` = 0.
- Jump: `jump_en_i` = 1, addr 0x100, FLUSH_CYCLES = 2 → cycle 0: `pc_jump_en_o` = 1, addr 0x100, `flush_o` = 1. Cycle 1: `flush_o` = 1, and a wrong-path `jump_en_i` = 1 with addr 0x200 is ignored. Cycle 2: `flush_o` = 0, `redirect_cnt_o` = 1.
- Deferred jump: `jump_en_i` = 1, addr 0x40, with `ext_hold_i` high for 3 cycles while `jump_addr_i` changes to 0x80 → `hold_o` = 1 and `pc_jump_en_o` = 0 for 3 cycles. Cycle 3: `pc_jump_en_o` = 1, addr 0x40.
- Watchdog: `hold_flag_i` high for 16 cycles, HOLD_MAX = 16 → `hold_timeout_o` = 1 after the 16th edge and stays 1 after release; `hold_o` drops the cycle the request drops.
- Misaligned target: addr 0x102 → `pc_jump_addr_o` = 0x100; `misalign_err_o` = 1 from the next cycle.
- Reset in PEND: assert `rst_n` low → outputs 0 immediately; after release with `ext_hold_i` = 0 and `jump_en_i` = 0, no redirect issues.
